// File: rtl/rect_render.sv
// ============================================================================
// Module      : rect_render
// Description : Streams one raster-order RGB565 frame per trigger: fg inside
//               a rectangle, bg elsewhere. Honours FIFO-full backpressure.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rect_render #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  input  logic [11:0] w,
  input  logic [11:0] h,
  input  logic [15:0] fg,
  input  logic [15:0] bg,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [15:0] fifo_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [11:0] C_PX_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] C_PY_LAST = 12'(V_ACTIVE - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_px;
  logic [11:0] r_py;
  logic [11:0] r_x0;
  logic [11:0] r_y0;
  logic [11:0] r_w;
  logic [11:0] r_h;
  logic [15:0] r_fg;
  logic [15:0] r_bg;
  logic        r_frame_done;
  logic        r_overrun;

  logic        w_write;
  logic        w_last_px;
  logic        w_last;
  logic        w_inside;

  assign w_write   = (r_state == S_RUN) && !fifo_full;
  assign w_last_px = (r_px == C_PX_LAST);
  assign w_last    = w_last_px && (r_py == C_PY_LAST);

  // Upper bounds in 13 bits so a rectangle running off the screen clips
  // instead of wrapping back to column/line zero.
  assign w_inside = ({1'b0, r_px} >= {1'b0, r_x0}) &&
                    ({1'b0, r_px} <  ({1'b0, r_x0} + {1'b0, r_w})) &&
                    ({1'b0, r_py} >= {1'b0, r_y0}) &&
                    ({1'b0, r_py} <  ({1'b0, r_y0} + {1'b0, r_h}));

  assign fifo_write = w_write;
  assign fifo_data  = (r_state == S_RUN) ? (w_inside ? r_fg : r_bg) : 16'h0000;
  assign busy       = (r_state == S_RUN);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (trigger) w_state_nxt = S_RUN;
      S_RUN: begin
        if (trigger) begin
          w_state_nxt = S_RUN;
        end else if (w_write && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_px         <= 12'd0;
      r_py         <= 12'd0;
      r_x0         <= 12'd0;
      r_y0         <= 12'd0;
      r_w          <= 12'd0;
      r_h          <= 12'd0;
      r_fg         <= 16'h0000;
      r_bg         <= 16'h0000;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_write && w_last;
      // A trigger coinciding with the final write is a clean hand-over.
      r_overrun    <= trigger && (r_state == S_RUN) && !(w_write && w_last);
      if (trigger) begin
        r_x0 <= x0;
        r_y0 <= y0;
        r_w  <= w;
        r_h  <= h;
        r_fg <= fg;
        r_bg <= bg;
        r_px <= 12'd0;
        r_py <= 12'd0;
      end else if (w_write) begin
        if (w_last) begin
          r_px <= 12'd0;
          r_py <= 12'd0;
        end else if (w_last_px) begin
          r_px <= 12'd0;
          r_py <= r_py + 12'd1;
        end else begin
          r_px <= r_px + 12'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
